// File: rtl/philv_decode_exec.sv
// PhilosophyV RV32I decode/execute slice: field split, immediate generation,
// ALU function decode, operand select, ALU, registered ALU output and load formatting.
module philv_decode_exec #(
  parameter int N       = 32,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               alu_override,
  input  logic               alu_src_a_sel,
  input  logic [1:0]         alu_src_b_sel,
  input  logic [N-1:0]       pc,
  input  logic [N-1:0]       rs1_data,
  input  logic [N-1:0]       rs2_data,
  input  logic [N-1:0]       dmem_rd_data,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic [N-1:0]       immed,
  output logic [FUNCT_W-1:0] alu_funct,
  output logic [N-1:0]       alu_result,
  output logic               alu_zero,
  output logic [N-1:0]       ex_out,
  output logic [N-1:0]       load_data
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [FUNCT_W-1:0] ALU_ADD  = FUNCT_W'(4'b0000);
  localparam logic [FUNCT_W-1:0] ALU_SUB  = FUNCT_W'(4'b1000);
  localparam logic [FUNCT_W-1:0] ALU_SLL  = FUNCT_W'(4'b0001);
  localparam logic [FUNCT_W-1:0] ALU_SLT  = FUNCT_W'(4'b0010);
  localparam logic [FUNCT_W-1:0] ALU_SLTU = FUNCT_W'(4'b0011);
  localparam logic [FUNCT_W-1:0] ALU_XOR  = FUNCT_W'(4'b0100);
  localparam logic [FUNCT_W-1:0] ALU_SRL  = FUNCT_W'(4'b0101);
  localparam logic [FUNCT_W-1:0] ALU_SRA  = FUNCT_W'(4'b1101);
  localparam logic [FUNCT_W-1:0] ALU_OR   = FUNCT_W'(4'b0110);
  localparam logic [FUNCT_W-1:0] ALU_AND  = FUNCT_W'(4'b0111);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [31:0]  imm32;
  logic [N-1:0] op_x;
  logic [N-1:0] op_y;
  logic [4:0]   shamt;
  logic [N-1:0] ex_out_d;
  logic [N-1:0] ex_out_q;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  always_comb begin
    imm32 = '0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign immed = N'($signed(imm32));

  // OP-IMM only honours instr[30] for shifts, so ADDI with a negative imm stays ADD
  always_comb begin
    alu_funct = ALU_ADD;
    if (alu_override) begin
      alu_funct = ALU_ADD;
    end else if (opcode == OPC_OP) begin
      alu_funct = FUNCT_W'({instr[30], funct3});
    end else if (opcode == OPC_OP_IMM) begin
      alu_funct = FUNCT_W'({(funct3 == 3'b101) ? instr[30] : 1'b0, funct3});
    end
  end

  always_comb begin
    op_x = alu_src_a_sel ? rs1_data : pc;
    op_y = '0;
    case (alu_src_b_sel)
      2'b00:   op_y = rs2_data;
      2'b01:   op_y = N'(4);
      2'b10:   op_y = immed;
      default: op_y = '0;
    endcase
  end

  assign shamt = op_y[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_funct)
      ALU_ADD:  alu_result = op_x + op_y;
      ALU_SUB:  alu_result = op_x - op_y;
      ALU_SLL:  alu_result = op_x << shamt;
      ALU_SLT:  alu_result = N'(($signed(op_x) < $signed(op_y)) ? 1 : 0);
      ALU_SLTU: alu_result = N'((op_x < op_y) ? 1 : 0);
      ALU_XOR:  alu_result = op_x ^ op_y;
      ALU_SRL:  alu_result = op_x >> shamt;
      ALU_SRA:  alu_result = $signed(op_x) >>> shamt;
      ALU_OR:   alu_result = op_x | op_y;
      ALU_AND:  alu_result = op_x & op_y;
      default:  alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == '0);

  always_comb begin
    ex_out_d = alu_result;
    if (rst) ex_out_d = '0;
  end

  always_ff @(posedge clk) begin
    ex_out_q <= ex_out_d;
  end

  assign ex_out = ex_out_q;

  always_comb begin
    load_data = dmem_rd_data;
    if (opcode == OPC_LOAD) begin
      case (funct3)
        3'b000:  load_data = N'($signed(dmem_rd_data[7:0]));
        3'b001:  load_data = N'($signed(dmem_rd_data[15:0]));
        3'b100:  load_data = N'(dmem_rd_data[7:0]);
        3'b101:  load_data = N'(dmem_rd_data[15:0]);
        default: load_data = dmem_rd_data;
      endcase
    end
  end

endmodule

// File: tb/tb_philv_decode_exec.sv
// Self-checking bench for philv_decode_exec: directed decode/ALU/load vectors plus
// a random R-type sweep; ex_out is checked through a queue one edge after each drive.
module tb_philv_decode_exec;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        alu_override;
  logic        alu_src_a_sel;
  logic [1:0]  alu_src_b_sel;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] dmem_rd_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] immed;
  logic [3:0]  alu_funct;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] ex_out;
  logic [31:0] load_data;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  philv_decode_exec #(.N(32), .FUNCT_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_override(alu_override),
    .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .dmem_rd_data(dmem_rd_data),
    .rs1(rs1), .rs2(rs2), .rd(rd), .immed(immed), .alu_funct(alu_funct),
    .alu_result(alu_result), .alu_zero(alu_zero), .ex_out(ex_out),
    .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one vector on the falling edge, check the combinational outputs,
  // then check ex_out against the queued value after the next rising edge.
  task automatic run_vec(input string tag, input logic [31:0] i, input logic ovr,
                         input logic asel, input logic [1:0] bsel, input logic [31:0] pcv,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] dm,
                         input logic rst_v, input logic [3:0] e_funct,
                         input logic [31:0] e_res, input logic [31:0] e_imm,
                         input logic [31:0] e_load);
    logic [31:0] e_ex;
    @(negedge clk);
    instr = i; alu_override = ovr; alu_src_a_sel = asel; alu_src_b_sel = bsel;
    pc = pcv; rs1_data = a; rs2_data = b; dmem_rd_data = dm; rst = rst_v;
    #1;
    chk({tag, ".funct"}, {28'd0, alu_funct}, {28'd0, e_funct});
    chk({tag, ".result"}, alu_result, e_res);
    chk({tag, ".zero"}, {31'd0, alu_zero}, {31'd0, (e_res == 32'd0)});
    chk({tag, ".immed"}, immed, e_imm);
    chk({tag, ".load"}, load_data, e_load);
    exp_q.push_back(rst_v ? 32'd0 : e_res);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".ex_out_queue"}, 32'd0, 32'd1);
    end else begin
      e_ex = exp_q.pop_front();
      chk({tag, ".ex_out"}, ex_out, e_ex);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (f)
      4'b0000: return a + b;
      4'b1000: return a + ~b + 32'd1;
      4'b0001: return a << b[4:0];
      4'b0010: return (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return sa >>> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [3:0]  codes [10];
    logic [3:0]  f;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0;
    n_fail   = 0;
    codes = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
              4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

    rst = 1'b1; instr = 32'h0000_0013; alu_override = 1'b0; alu_src_a_sel = 1'b1;
    alu_src_b_sel = 2'b00; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    dmem_rd_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ex_out", ex_out, 32'd0);

    // ADD x3,x1,x2 with field split check
    run_vec("add", 32'h002081B3, 0, 1, 2'b00, 32'h1000, 32'd7, 32'd5, 32'hDEADBEEF, 0,
            4'b0000, 32'd12, 32'd0, 32'hDEADBEEF);
    chk("add.rs1", {27'd0, rs1}, 32'd1);
    chk("add.rs2", {27'd0, rs2}, 32'd2);
    chk("add.rd",  {27'd0, rd},  32'd3);

    run_vec("sub", 32'h402081B3, 0, 1, 2'b00, 32'h1000, 32'd5, 32'd7, 32'h0, 0,
            4'b1000, 32'hFFFFFFFE, 32'd0, 32'h0);
    run_vec("sub_eq", 32'h402081B3, 0, 1, 2'b00, 32'h1000, 32'd9, 32'd9, 32'h0, 0,
            4'b1000, 32'd0, 32'd0, 32'h0);
    run_vec("slt", 32'h0020A1B3, 0, 1, 2'b00, 32'h1000, 32'hFFFFFFFE, 32'd1, 32'h0, 0,
            4'b0010, 32'd1, 32'd0, 32'h0);
    run_vec("sltu", 32'h0020B1B3, 0, 1, 2'b00, 32'h1000, 32'hFFFFFFFE, 32'd1, 32'h0, 0,
            4'b0011, 32'd0, 32'd0, 32'h0);
    run_vec("unlisted", 32'h402091B3, 0, 1, 2'b00, 32'h1000, 32'd5, 32'd1, 32'h0, 0,
            4'b1001, 32'd0, 32'd0, 32'h0);
    run_vec("addi_m1", 32'hFFF08093, 0, 1, 2'b10, 32'h1000, 32'd10, 32'd0, 32'h0, 0,
            4'b0000, 32'd9, 32'hFFFFFFFF, 32'h0);
    run_vec("srai", 32'h40415093, 0, 1, 2'b10, 32'h1000, 32'h80000000, 32'd0, 32'h0, 0,
            4'b1101, 32'hF8000000, 32'h00000404, 32'h0);
    run_vec("lb", 32'h00410083, 0, 1, 2'b10, 32'h1000, 32'h100, 32'd0, 32'h000000F0, 0,
            4'b0000, 32'h104, 32'd4, 32'hFFFFFFF0);
    run_vec("lbu", 32'h00414083, 0, 1, 2'b10, 32'h1000, 32'h100, 32'd0, 32'h000000F0, 0,
            4'b0000, 32'h104, 32'd4, 32'h000000F0);
    run_vec("lh", 32'h00411083, 0, 1, 2'b10, 32'h1000, 32'h100, 32'd0, 32'h00008001, 0,
            4'b0000, 32'h104, 32'd4, 32'hFFFF8001);
    run_vec("lhu", 32'h00415083, 0, 1, 2'b10, 32'h1000, 32'h100, 32'd0, 32'h12348001, 0,
            4'b0000, 32'h104, 32'd4, 32'h00008001);
    run_vec("lw", 32'h00412083, 0, 1, 2'b10, 32'h1000, 32'h100, 32'd0, 32'h12348001, 0,
            4'b0000, 32'h104, 32'd4, 32'h12348001);
    run_vec("sw", 32'hFE20AC23, 0, 1, 2'b10, 32'h1000, 32'h200, 32'd0, 32'h000000F0, 0,
            4'b0000, 32'h1F8, 32'hFFFFFFF8, 32'h000000F0);
    run_vec("beq", 32'hFE000EE3, 0, 0, 2'b10, 32'h1000, 32'd0, 32'd0, 32'h0, 0,
            4'b0000, 32'h0FFC, 32'hFFFFFFFC, 32'h0);
    run_vec("jal", 32'h0080006F, 0, 0, 2'b01, 32'h1000, 32'd0, 32'd0, 32'h0, 0,
            4'b0000, 32'h1004, 32'd8, 32'h0);
    run_vec("lui", 32'h123450B7, 0, 0, 2'b11, 32'h1000, 32'd0, 32'd0, 32'h0, 0,
            4'b0000, 32'h1000, 32'h12345000, 32'h0);
    run_vec("override", 32'h402081B3, 1, 1, 2'b00, 32'h1000, 32'd5, 32'd7, 32'h0, 0,
            4'b0000, 32'd12, 32'd0, 32'h0);
    run_vec("rst_hold", 32'h002081B3, 0, 1, 2'b00, 32'h1000, 32'h1000, 32'h234, 32'h0, 1,
            4'b0000, 32'h1234, 32'd0, 32'h0);
    run_vec("rst_rel", 32'h002081B3, 0, 1, 2'b00, 32'h1000, 32'h1000, 32'h234, 32'h0, 0,
            4'b0000, 32'h1234, 32'd0, 32'h0);

    for (int k = 0; k < 24; k++) begin
      f  = codes[$urandom_range(0, 9)];
      ra = $urandom;
      rb = $urandom;
      run_vec("rand_op", {1'b0, f[3], 5'd0, 5'd2, 5'd1, f[2:0], 5'd3, 7'b0110011}, 0, 1,
              2'b00, 32'h1000, ra, rb, 32'h55AA33CC, 0, f, model(f, ra, rb), 32'd0,
              32'h55AA33CC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
